hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter REG_W, default 5, register-address width.
REQ-002 Parameter LOAD_LAT, default 1, range 1..7, total load-use stall cycles per hazard.
REQ-003 Parameter CNT_W, default 16, stall-statistics counter width.
REQ-004 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 id_op, id_funct  in  6 each  opcode and funct of the IF/ID instruction.
REQ-008 id_rs, id_rt  in  REG_W each  IF/ID source registers; id_rt_valid  in  1  id_rt is a real source.
REQ-009 ex_mem_read, ex_reg_write  in  1 each; ex_dst  in  REG_W  ID/EX instruction destination.
REQ-010 mem_mem_read, mem_reg_write  in  1 each; mem_dst  in  REG_W  EX/MEM instruction destination.
REQ-011 br_taken  in  1  ID-stage comparator result, rs==rt.
REQ-012 dmem_busy  in  1  data memory not ready; whole pipeline holds.
REQ-013 stat_clr  in  1  synchronous clear of stall_cnt.
REQ-014 pc_stall, if_id_stall, if_id_flush, id_ex_bubble  out  1 each  pipeline controls.
REQ-015 stall_cnt  out  CNT_W  saturating stall-cycle count; state  out  2  00 RUN, 01 LDWAIT, 10 FREEZE.

Function
REQ-016 A match SHALL require equal addresses with the destination nonzero; register 0 never hazards; rt match additionally requires id_rt_valid.
REQ-017 Opcodes: R=000000, J=000010, JAL=000011, BEQ=000100, BNE=000101; JR = R with funct 001000.
REQ-018 Outputs SHALL be combinational from registered state and current inputs, evaluated in strict priority order per REQ-019..REQ-024.
REQ-019 P1 dmem_busy=1: pc_stall=1, if_id_stall=1, id_ex_bubble=0, if_id_flush=0; next state FREEZE; LDWAIT remaining count held, not decremented.
REQ-020 P2 remaining count nonzero: pc_stall=if_id_stall=id_ex_bubble=1, flush=0; count decrements by 1 per cycle; LDWAIT exits to RUN on the cycle the count reaches 0.
REQ-021 P3 load-use (ex_mem_read and ex_dst matches rs or rt): pc_stall=if_id_stall=id_ex_bubble=1, flush=0; count loads LOAD_LAT-1; state LDWAIT if LOAD_LAT>1, else RUN.
REQ-022 P4 branch dependency (BEQ, BNE or JR in ID, and either ex_reg_write with ex_dst match or mem_reg_write and mem_mem_read with mem_dst match): stall and bubble as P3; no counter load.
REQ-023 P5 control transfer (J, JAL, JR, BEQ with br_taken=1, BNE with br_taken=0): if_id_flush=1, all others 0.
REQ-024 P6 otherwise all four controls SHALL be 0.
REQ-025 if_id_flush SHALL never be 1 in a cycle where pc_stall=1.
REQ-026 FREEZE SHALL return to LDWAIT if the held count is nonzero, else to RUN, on the first cycle dmem_busy=0.
REQ-027 stall_cnt SHALL increment by 1 on each clock edge where pc_stall=1, saturating at all-ones.
REQ-028 stat_clr SHALL zero stall_cnt and take priority over the increment.
REQ-029 With LOAD_LAT=1 and dmem_busy=0, the controls SHALL equal the single-cycle hazard-detection behaviour.

Reset
REQ-030 rst_n=0 SHALL immediately set state=RUN, count=0, stall_cnt=0, and force all four controls to 0 regardless of inputs.
REQ-031 Reset asserted mid-LDWAIT or FREEZE SHALL abandon the stall; after release the block re-evaluates from RUN.

Verification
REQ-032 LOAD_LAT=3: ex_mem_read=1, ex_dst=8, id_rs=8 -> stall+bubble 3 consecutive cycles, state 01 for cycles 2..3, stall_cnt=3.
REQ-033 ex_mem_read=1, ex_dst=0, id_rs=0 -> no stall; id_rt=8, id_rt_valid=0, ex_dst=8 -> no stall.
REQ-034 BEQ in ID, ex_reg_write=1, ex_dst=5, id_rt=5 -> one stall cycle; next cycle ex_reg_write=0, br_taken=1 -> if_id_flush=1, pc_stall=0.
REQ-035 LOAD_LAT=3, dmem_busy=1 for 2 cycles during second LDWAIT cycle -> state 10, bubble=0, count held; then one further stall cycle; stall_cnt=5.
REQ-036 CNT_W=4, 20 stall cycles -> stall_cnt stays 15; stat_clr=1 with pc_stall=1 -> stall_cnt=0.
REQ-037 rst_n=0 asserted mid-LDWAIT -> controls 0 in same cycle, state 00, stall_cnt 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch hazard stall controller with multi-cycle load
// latency, memory freeze handling and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_op,
    input  logic [5:0]       id_funct,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_valid,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             mem_mem_read,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             br_taken,
    input  logic             dmem_busy,
    input  logic             stat_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        LDWAIT = 2'b01,
        FREEZE = 2'b10
    } state_e;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit, mem_hit;
    logic is_jr, is_beq, is_bne, is_j, is_jal;
    logic load_use, br_dep, ctl_xfer;
    logic pc_s, ifid_s, flush_s, bub_s;

    // Register 0 is hardwired, so it can never carry a dependency.
    assign ex_hit = (ex_dst != '0) &&
                    ((id_rs == ex_dst) ||
                     (id_rt_valid && (id_rt == ex_dst)));
    assign mem_hit = (mem_dst != '0) &&
                     ((id_rs == mem_dst) ||
                      (id_rt_valid && (id_rt == mem_dst)));

    assign is_jr  = (id_op == OP_R) && (id_funct == FN_JR);
    assign is_beq = (id_op == OP_BEQ);
    assign is_bne = (id_op == OP_BNE);
    assign is_j   = (id_op == OP_J);
    assign is_jal = (id_op == OP_JAL);

    assign load_use = ex_mem_read && ex_hit;
    assign br_dep   = (is_beq || is_bne || is_jr) &&
                      ((ex_reg_write && ex_hit) ||
                       (mem_reg_write && mem_mem_read && mem_hit));
    assign ctl_xfer = is_j || is_jal || is_jr ||
                      (is_beq && br_taken) ||
                      (is_bne && !br_taken);

    always_comb begin
        pc_s    = 1'b0;
        ifid_s  = 1'b0;
        flush_s = 1'b0;
        bub_s   = 1'b0;
        cnt_d   = cnt_q;
        state_d = RUN;
        if (dmem_busy) begin
            pc_s    = 1'b1;
            ifid_s  = 1'b1;
            state_d = FREEZE;
        end else if (cnt_q != 3'd0) begin
            pc_s    = 1'b1;
            ifid_s  = 1'b1;
            bub_s   = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q == 3'd1) ? RUN : LDWAIT;
        end else if (load_use) begin
            pc_s    = 1'b1;
            ifid_s  = 1'b1;
            bub_s   = 1'b1;
            cnt_d   = LAT_M1;
            state_d = (LOAD_LAT > 1) ? LDWAIT : RUN;
        end else if (br_dep) begin
            pc_s    = 1'b1;
            ifid_s  = 1'b1;
            bub_s   = 1'b1;
        end else if (ctl_xfer) begin
            flush_s = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (pc_s && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset forces the controls low combinationally, not just at the edge.
    assign pc_stall     = rst_n && pc_s;
    assign if_id_stall  = rst_n && ifid_s;
    assign if_id_flush  = rst_n && flush_s;
    assign id_ex_bubble = rst_n && bub_s;
    assign stall_cnt    = stall_cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random
// stimulus against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int LL = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] id_op, id_funct;
    logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
    logic id_rt_valid, ex_mem_read, ex_reg_write;
    logic mem_mem_read, mem_reg_write, br_taken;
    logic dmem_busy, stat_clr;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
    logic pc_stall1, if_id_stall1, if_id_flush1, id_ex_bubble1;
    logic [3:0] stall_cnt;
    logic [3:0] stall_cnt1;
    logic [1:0] state, state1;
    wire  [3:0] ctl  = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble};
    wire  [3:0] ctl1 = {pc_stall1, if_id_stall1, if_id_flush1, id_ex_bubble1};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(LL), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rt_valid(id_rt_valid),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dst(ex_dst), .mem_mem_read(mem_mem_read),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
        .br_taken(br_taken), .dmem_busy(dmem_busy), .stat_clr(stat_clr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .stall_cnt(stall_cnt), .state(state)
    );

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rt_valid(id_rt_valid),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dst(ex_dst), .mem_mem_read(mem_mem_read),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
        .br_taken(br_taken), .dmem_busy(dmem_busy), .stat_clr(stat_clr),
        .pc_stall(pc_stall1), .if_id_stall(if_id_stall1),
        .if_id_flush(if_id_flush1), .id_ex_bubble(id_ex_bubble1),
        .stall_cnt(stall_cnt1), .state(state1)
    );

    task automatic idle();
        id_op = 6'd35; id_funct = 6'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rt_valid = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
        mem_mem_read = 1'b0; mem_reg_write = 1'b0; mem_dst = 5'd0;
        br_taken = 1'b0; dmem_busy = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_lu();
        dmem_busy = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 4'b0000)
            begin n_bad++; $display("FAIL reset_ctl got %b want 0000", ctl); end
        n_cmp++;
        if (state !== 2'b00 || stall_cnt !== 4'd0)
            begin n_bad++; $display("FAIL reset_regs got st=%b cnt=%0d want 00/0", state, stall_cnt); end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu();
        #1;
        n_cmp++;
        if (ctl !== 4'b1101 || state !== 2'b00)
            begin n_bad++; $display("FAIL lu_c1 got %b/%b want 1101/00", ctl, state); end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (ctl !== 4'b1101 || state !== 2'b01)
                begin n_bad++; $display("FAIL lu_c%0d got %b/%b want 1101/01", c, ctl, state); end
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (ctl !== 4'b0000 || state !== 2'b00 || stall_cnt !== 4'd3)
            begin n_bad++; $display("FAIL lu_end got %b/%b/%0d want 0000/00/3", ctl, state, stall_cnt); end
    endtask

    task automatic test_reg0();
        do_reset();
        ex_mem_read = 1'b1; ex_dst = 5'd0; id_rs = 5'd0;
        #1;
        n_cmp++;
        if (ctl !== 4'b0000)
            begin n_bad++; $display("FAIL reg0 got %b want 0000", ctl); end
        id_rs = 5'd3; id_rt = 5'd8; id_rt_valid = 1'b0; ex_dst = 5'd8;
        #1;
        n_cmp++;
        if (ctl !== 4'b0000)
            begin n_bad++; $display("FAIL rt_invalid got %b want 0000", ctl); end
        id_rt_valid = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 4'b1101)
            begin n_bad++; $display("FAIL rt_valid got %b want 1101", ctl); end
        do_reset();
    endtask

    task automatic test_branch();
        do_reset();
        id_op = 6'd4; id_rs = 5'd2; id_rt = 5'd5; id_rt_valid = 1'b1;
        ex_reg_write = 1'b1; ex_dst = 5'd5;
        #1;
        n_cmp++;
        if (ctl !== 4'b1101)
            begin n_bad++; $display("FAIL br_dep got %b want 1101", ctl); end
        @(negedge clk);
        ex_reg_write = 1'b0; br_taken = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 4'b0010)
            begin n_bad++; $display("FAIL beq_taken got %b want 0010", ctl); end
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dst = 5'd2;
        #1;
        n_cmp++;
        if (ctl !== 4'b1101)
            begin n_bad++; $display("FAIL br_memdep got %b want 1101", ctl); end
        mem_mem_read = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== 4'b0010)
            begin n_bad++; $display("FAIL br_memalu got %b want 0010", ctl); end
        mem_reg_write = 1'b0;
        id_op = 6'd5;
        #1;
        n_cmp++;
        if (ctl !== 4'b0000)
            begin n_bad++; $display("FAIL bne_taken got %b want 0000", ctl); end
        br_taken = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== 4'b0010)
            begin n_bad++; $display("FAIL bne_nt got %b want 0010", ctl); end
        id_op = 6'd0; id_funct = 6'd8;
        #1;
        n_cmp++;
        if (ctl !== 4'b0010)
            begin n_bad++; $display("FAIL jr got %b want 0010", ctl); end
        id_op = 6'd3;
        #1;
        n_cmp++;
        if (ctl !== 4'b0010)
            begin n_bad++; $display("FAIL jal got %b want 0010", ctl); end
        do_reset();
    endtask

    task automatic test_freeze();
        do_reset();
        set_lu();
        #1;
        n_cmp++;
        if (ctl !== 4'b1101)
            begin n_bad++; $display("FAIL fz_c1 got %b want 1101", ctl); end
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== 4'b1101 || state !== 2'b01)
            begin n_bad++; $display("FAIL fz_c2 got %b/%b want 1101/01", ctl, state); end
        @(negedge clk);
        dmem_busy = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 4'b1100 || state !== 2'b01)
            begin n_bad++; $display("FAIL fz_c3 got %b/%b want 1100/01", ctl, state); end
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== 4'b1100 || state !== 2'b10)
            begin n_bad++; $display("FAIL fz_c4 got %b/%b want 1100/10", ctl, state); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (ctl !== 4'b1101 || state !== 2'b10)
            begin n_bad++; $display("FAIL fz_c5 got %b/%b want 1101/10", ctl, state); end
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== 4'b0000 || state !== 2'b00 || stall_cnt !== 4'd5)
            begin n_bad++; $display("FAIL fz_end got %b/%b/%0d want 0000/00/5", ctl, state, stall_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        dmem_busy = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        n_cmp++;
        if (stall_cnt !== 4'd15)
            begin n_bad++; $display("FAIL sat got %0d want 15", stall_cnt); end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        n_cmp++;
        if (stall_cnt !== 4'd0)
            begin n_bad++; $display("FAIL clr got %0d want 0", stall_cnt); end
        @(negedge clk); #1;
        n_cmp++;
        if (stall_cnt !== 4'd1)
            begin n_bad++; $display("FAIL post_clr got %0d want 1", stall_cnt); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_lu();
        @(negedge clk); #1;
        n_cmp++;
        if (state !== 2'b01)
            begin n_bad++; $display("FAIL rm_pre got %b want 01", state); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== 4'b0000 || state !== 2'b00 || stall_cnt !== 4'd0)
            begin n_bad++; $display("FAIL rm_rst got %b/%b/%0d want 0000/00/0", ctl, state, stall_cnt); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 4'b0000 || state !== 2'b00)
            begin n_bad++; $display("FAIL rm_post got %b/%b want 0000/00", ctl, state); end
    endtask

    function automatic bit hit(input logic [4:0] d);
        return (d != 5'd0) &&
               ((id_rs == d) || (id_rt_valid && id_rt == d));
    endfunction

    function automatic bit m_lu();
        return ex_mem_read && hit(ex_dst);
    endfunction

    function automatic logic [3:0] m_ctl(input int rem);
        bit jr, isbr, bd, ct;
        jr   = (id_op == 6'd0) && (id_funct == 6'd8);
        isbr = (id_op == 6'd4) || (id_op == 6'd5) || jr;
        bd   = isbr && ((ex_reg_write && hit(ex_dst)) ||
                        (mem_reg_write && mem_mem_read && hit(mem_dst)));
        ct   = (id_op == 6'd2) || (id_op == 6'd3) || jr ||
               (id_op == 6'd4 && br_taken) || (id_op == 6'd5 && !br_taken);
        if (dmem_busy) return 4'b1100;
        if (rem > 0) return 4'b1101;
        if (m_lu() || bd) return 4'b1101;
        if (ct) return 4'b0010;
        return 4'b0000;
    endfunction

    task automatic test_random();
        int rem, scnt;
        bit frozen;
        logic [3:0] ec, ec1;
        logic [1:0] es;
        logic [5:0] ops[7];
        logic [5:0] fns[3];
        ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd35, 6'd43};
        fns = '{6'd0, 6'd8, 6'd32};
        do_reset();
        rem = 0; scnt = 0; frozen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            id_op = ops[$urandom_range(0, 6)];
            id_funct = fns[$urandom_range(0, 2)];
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_rt_valid = 1'($urandom);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_reg_write = 1'($urandom);
            ex_dst = 5'($urandom_range(0, 3));
            mem_mem_read = 1'($urandom);
            mem_reg_write = 1'($urandom);
            mem_dst = 5'($urandom_range(0, 3));
            br_taken = 1'($urandom);
            dmem_busy = ($urandom_range(0, 7) == 0);
            stat_clr = ($urandom_range(0, 31) == 0);
            #1;
            ec  = m_ctl(rem);
            ec1 = m_ctl(0);
            es  = frozen ? 2'b10 : (rem > 0 ? 2'b01 : 2'b00);
            n_cmp++;
            if (ctl !== ec)
                begin n_bad++; $display("FAIL rnd_ctl[%0d] got %b want %b", i, ctl, ec); end
            n_cmp++;
            if (state !== es)
                begin n_bad++; $display("FAIL rnd_state[%0d] got %b want %b", i, state, es); end
            n_cmp++;
            if (stall_cnt !== 4'(scnt))
                begin n_bad++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, stall_cnt, scnt); end
            n_cmp++;
            if (ctl1 !== ec1)
                begin n_bad++; $display("FAIL rnd_ll1[%0d] got %b want %b", i, ctl1, ec1); end
            if (stat_clr) scnt = 0;
            else if (ec[3] && scnt < 15) scnt++;
            if (dmem_busy) frozen = 1;
            else begin
                frozen = 0;
                if (rem > 0) rem--;
                else if (m_lu()) rem = LL - 1;
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_reg0();
        test_branch();
        test_freeze();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
